// File: rtl/week6_ex1_xor_arbiter_if.sv
// rtl/week6_ex1_xor_arbiter_if.sv - request/result bundle for the shared XOR arbiter
// Purpose: groups the per-requester request/operand inputs and the grant/result
//   outputs of week6_ex1_xor_arbiter into one interface.
// Signals:
//   req     NREQ        per-requester request level
//   a_bus   NREQ*WIDTH  operand A, requester i at [i*WIDTH +: WIDTH]
//   b_bus   NREQ*WIDTH  operand B, same packing
//   gnt     NREQ        one-hot grant
//   gnt_id  IDW         index of current/last grantee
//   busy    1           operation in progress
//   y       WIDTH       registered XOR result
//   done    1           one-cycle result strobe
//   y_par   1           parity of y (only with XOR_ARB_PARITY_EN)
// Modports: master = requester side, slave = arbiter side.
interface week6_ex1_xor_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int IDW   = 2
);
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] a_bus;
  logic [NREQ*WIDTH-1:0] b_bus;
  logic [NREQ-1:0]       gnt;
  logic [IDW-1:0]        gnt_id;
  logic                  busy;
  logic [WIDTH-1:0]      y;
  logic                  done;
`ifdef XOR_ARB_PARITY_EN
  logic                  y_par;

  modport master (output req, a_bus, b_bus,
                  input  gnt, gnt_id, busy, y, done, y_par);
  modport slave  (input  req, a_bus, b_bus,
                  output gnt, gnt_id, busy, y, done, y_par);
`else
  modport master (output req, a_bus, b_bus,
                  input  gnt, gnt_id, busy, y, done);
  modport slave  (input  req, a_bus, b_bus,
                  output gnt, gnt_id, busy, y, done);
`endif
endinterface

// File: rtl/week6_ex1_xor_arbiter.sv
// rtl/week6_ex1_xor_arbiter.sv - round-robin shared registered XOR datapath
// Purpose: NREQ requesters share one y = a ^ b register. A round-robin arbiter
//   picks one requester in IDLE, its operands are latched at grant, the result is
//   registered in CAPT and presented with a one-cycle done pulse in RESP.
// Ports:
//   clk    in  rising-edge clock
//   rst_n  in  asynchronous active-low reset
//   bus    slave modport of week6_ex1_xor_arbiter_if (req/a_bus/b_bus in,
//          gnt/gnt_id/busy/y/done[/y_par] out)
// Optional feature macro: XOR_ARB_PARITY_EN adds bus.y_par = ^y, registered with y.
module week6_ex1_xor_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int IDW   = $clog2(NREQ)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  week6_ex1_xor_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CAPT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;

  logic [IDW-1:0]   ptr;        // last grantee; search starts one past it
  logic [IDW-1:0]   gnt_id_q;
  logic [IDW-1:0]   win;
  logic             win_vld;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] y_q;

  logic             busy_c;
  logic             done_c;
  logic [NREQ-1:0]  gnt_c;

  // Round-robin pick: first set request scanning ptr+1, ptr+2, ... modulo NREQ.
  // The scan covers NREQ slots so ptr itself is checked last, which lets a lone
  // repeat requester still win.
  always_comb begin
    int             idx;
    logic [IDW-1:0] sel;
    win     = '0;
    win_vld = 1'b0;
    idx     = 0;
    sel     = '0;
    for (int i = 1; i <= NREQ; i++) begin
      idx = (int'(ptr) + i) % NREQ;
      sel = IDW'(idx);
      if (!win_vld && bus.req[sel]) begin
        win     = sel;
        win_vld = 1'b1;
      end
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (win_vld) state_nxt = CAPT;
      CAPT:    state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic: grant is decoded from the registered index while busy
  always_comb begin
    busy_c = 1'b0;
    done_c = 1'b0;
    gnt_c  = '0;
    case (state)
      CAPT: begin
        busy_c          = 1'b1;
        gnt_c[gnt_id_q] = 1'b1;
      end
      RESP: begin
        busy_c          = 1'b1;
        done_c          = 1'b1;
        gnt_c[gnt_id_q] = 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath: operands latched once at grant, result registered in CAPT.
  // The pointer only advances when the op actually reaches CAPT, so an op
  // aborted by reset leaves arbitration history untouched (reset restores it).
`ifdef XOR_ARB_PARITY_EN
  logic y_par_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr      <= IDW'(NREQ - 1);
      gnt_id_q <= '0;
      a_q      <= '0;
      b_q      <= '0;
      y_q      <= '0;
`ifdef XOR_ARB_PARITY_EN
      y_par_q  <= 1'b0;
`endif
    end else begin
      if (state == IDLE && win_vld) begin
        gnt_id_q <= win;
        a_q      <= bus.a_bus[int'(win)*WIDTH +: WIDTH];
        b_q      <= bus.b_bus[int'(win)*WIDTH +: WIDTH];
      end
      if (state == CAPT) begin
        y_q <= a_q ^ b_q;
        ptr <= gnt_id_q;
`ifdef XOR_ARB_PARITY_EN
        y_par_q <= ^(a_q ^ b_q);
`endif
      end
    end
  end

  assign bus.gnt    = gnt_c;
  assign bus.gnt_id = gnt_id_q;
  assign bus.busy   = busy_c;
  assign bus.done   = done_c;
  assign bus.y      = y_q;
`ifdef XOR_ARB_PARITY_EN
  assign bus.y_par  = y_par_q;
`endif

endmodule

// File: tb/tb_week6_ex1_xor_arbiter.sv
// tb/tb_week6_ex1_xor_arbiter.sv - scoreboard bench for week6_ex1_xor_arbiter
module tb_week6_ex1_xor_arbiter;
  localparam int NREQ  = 4;
  localparam int WIDTH = 8;
  localparam int IDW   = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  week6_ex1_xor_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) bus_if();

  week6_ex1_xor_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  typedef struct packed {
    logic [IDW-1:0]   id;
    logic [WIDTH-1:0] y;
  } exp_t;

  exp_t             exp_q[$];
  int               checks = 0;
  int               errors = 0;
  int               last_w;
  logic [WIDTH-1:0] last_y;
  logic [WIDTH-1:0] a_m [NREQ];
  logic [WIDTH-1:0] b_m [NREQ];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, want);
    end
  endtask

  // Reference rule: the winner is the first requester met walking forward
  // from the previous winner, wrapping around.
  function automatic int model_winner(input logic [NREQ-1:0] r);
    for (int k = 1; k <= NREQ; k++)
      if (r[(last_w + k) % NREQ]) return (last_w + k) % NREQ;
    return -1;
  endfunction

  task automatic drive_operands();
    for (int i = 0; i < NREQ; i++) begin
      bus_if.a_bus[i*WIDTH +: WIDTH] = a_m[i];
      bus_if.b_bus[i*WIDTH +: WIDTH] = b_m[i];
    end
  endtask

  // Starts at a negedge with the DUT idle, ends at a negedge with the DUT idle.
  // mode: 0 keep operands, 1 zero all A operands in CAPT, 2 randomise all in CAPT.
  task automatic run_op(input logic [NREQ-1:0] r, input int mode, input bit drop);
    int   w;
    exp_t e;
    w = model_winner(r);
    e.id = IDW'(w);
    e.y  = a_m[w] ^ b_m[w];
    exp_q.push_back(e);
    last_w = w;
    last_y = e.y;
    bus_if.req = r;
    drive_operands();
    @(negedge clk);
    check("grant_k1", {28'd0, bus_if.gnt}, 32'd1 << w);
    check("gnt_id_k1", {30'd0, bus_if.gnt_id}, w);
    check("busy_capt", {31'd0, bus_if.busy}, 1);
    check("no_done_capt", {31'd0, bus_if.done}, 0);
    if (mode == 1) begin
      for (int i = 0; i < NREQ; i++) a_m[i] = '0;
      drive_operands();
    end else if (mode == 2) begin
      for (int i = 0; i < NREQ; i++) begin
        a_m[i] = WIDTH'($urandom);
        b_m[i] = WIDTH'($urandom);
      end
      drive_operands();
    end
    if (drop) bus_if.req = '0;
    @(negedge clk);
    check("done_k2", {31'd0, bus_if.done}, 1);
    if (bus_if.done !== 1'b1 && exp_q.size() > 0) void'(exp_q.pop_back());
    bus_if.req = '0;
    @(negedge clk);
    check("idle_after_resp", {31'd0, bus_if.busy}, 0);
  endtask

  // Monitor: pops the scoreboard on every done and checks the invariants.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if ($countones(bus_if.gnt) > 1 || (!bus_if.busy && bus_if.gnt != '0)) begin
        checks++;
        errors++;
        $display("FAIL gnt_invariant: gnt=%b busy=%b", bus_if.gnt, bus_if.busy);
      end
      if (bus_if.done === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: gnt_id=%0d y=%0h expected no result", bus_if.gnt_id, bus_if.y);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("mon_y", {24'd0, bus_if.y}, {24'd0, e.y});
          check("mon_gnt_id", {30'd0, bus_if.gnt_id}, {30'd0, e.id});
          check("mon_gnt", {28'd0, bus_if.gnt}, 32'd1 << e.id);
`ifdef XOR_ARB_PARITY_EN
          check("mon_y_par", {31'd0, bus_if.y_par}, {31'd0, ^e.y});
`endif
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    // T1: reset held with every request up
    rst_n = 1'b0;
    bus_if.req = 4'hF;
    for (int i = 0; i < NREQ; i++) begin
      a_m[i] = WIDTH'($urandom);
      b_m[i] = WIDTH'($urandom);
    end
    drive_operands();
    last_w = NREQ - 1;
    last_y = '0;
    repeat (4) begin
      @(negedge clk);
      check("rst_gnt", {28'd0, bus_if.gnt}, 0);
      check("rst_busy", {31'd0, bus_if.busy}, 0);
      check("rst_y", {24'd0, bus_if.y}, 0);
      check("rst_done", {31'd0, bus_if.done}, 0);
    end
    check("rst_gnt_id", {30'd0, bus_if.gnt_id}, 0);
    bus_if.req = '0;
    rst_n = 1'b1;

    // T3: all requesting, expect order 0,1,2,3,0
    for (int i = 0; i < NREQ; i++) begin
      a_m[i] = WIDTH'(i);
      b_m[i] = 8'hFF;
    end
    for (int n = 0; n < 5; n++) run_op(4'hF, 0, 1'b0);

    // T2: single requester 0
    a_m[0] = 8'hF0;
    b_m[0] = 8'h3C;
    run_op(4'b0001, 0, 1'b0);

    // T4: operand change during CAPT is ignored
    a_m[2] = 8'hAA;
    b_m[2] = 8'h55;
    run_op(4'b0100, 1, 1'b0);

    // idle: outputs hold with no requests
    repeat (3) begin
      @(negedge clk);
      check("idle_done", {31'd0, bus_if.done}, 0);
      check("idle_y_hold", {24'd0, bus_if.y}, {24'd0, last_y});
      check("idle_busy", {31'd0, bus_if.busy}, 0);
    end

    // T5: reset during CAPT aborts, next grant goes to requester 0
    bus_if.req = 4'b0100;
    @(negedge clk);
    check("t5_busy_capt", {31'd0, bus_if.busy}, 1);
    rst_n = 1'b0;
    bus_if.req = '0;
    #1;
    check("t5_rst_busy", {31'd0, bus_if.busy}, 0);
    check("t5_rst_gnt", {28'd0, bus_if.gnt}, 0);
    check("t5_rst_y", {24'd0, bus_if.y}, 0);
    repeat (2) begin
      @(negedge clk);
      check("t5_rst_done", {31'd0, bus_if.done}, 0);
    end
    rst_n = 1'b1;
    last_w = NREQ - 1;
    last_y = '0;
    run_op(4'hF, 0, 1'b0);

    // T6 operand patterns (parity checked by the monitor when enabled)
    a_m[1] = 8'h01; b_m[1] = 8'h00;
    run_op(4'b0010, 0, 1'b0);
    a_m[3] = 8'h0F; b_m[3] = 8'h0F;
    run_op(4'b1000, 0, 1'b0);

    // randomized traffic with operand corruption, request drops and idle gaps
    for (int n = 0; n < 60; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        a_m[i] = WIDTH'($urandom);
        b_m[i] = WIDTH'($urandom);
      end
      run_op(NREQ'($urandom_range(1, (1 << NREQ) - 1)), int'($urandom_range(0, 2)),
             1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) begin
          @(negedge clk);
          check("gap_y_hold", {24'd0, bus_if.y}, {24'd0, last_y});
        end
      end
    end

    @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
